// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Command-issuing front end for the combinational integer ALU. Commands
//   arrive on a valid/ready stream and are queued in a small FIFO. Each
//   command is popped, and its operands are fetched from a local register
//   file, or from an immediate for operand B. The operands and opcode are
//   presented to the ALU for one cycle. The result is written back to the
//   register file and returned on a valid/ready response stream together
//   with the ALU flags.
//
// Ports
//   clk, rst_n                 clock (rising edge) and async active-low reset
//   cmd_valid / cmd_ready      command stream handshake
//   cmd_op, cmd_rs1, cmd_rs2   opcode and source register indices
//   cmd_rd                     destination register index
//   cmd_use_imm, cmd_imm       select immediate as operand B, immediate value
//   alu_a, alu_b, alu_op       registered ALU operands and opcode
//   alu_result, alu_zero/neg   combinational ALU result and flags
//   rsp_valid / rsp_ready      response stream handshake
//   rsp_data, rsp_rd           captured result and its destination register
//   rsp_zero, rsp_neg          captured ALU flags
//   busy                       work queued or in flight (registered)
module alu_cmd_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_SEL     = 4,
  parameter int NREGS      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [OP_SEL-1:0]         cmd_op,
  input  logic [$clog2(NREGS)-1:0]  cmd_rs1,
  input  logic [$clog2(NREGS)-1:0]  cmd_rs2,
  input  logic [$clog2(NREGS)-1:0]  cmd_rd,
  input  logic                      cmd_use_imm,
  input  logic [DATA_WIDTH-1:0]     cmd_imm,
  output logic [DATA_WIDTH-1:0]     alu_a,
  output logic [DATA_WIDTH-1:0]     alu_b,
  output logic [OP_SEL-1:0]         alu_op,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic                      alu_zero,
  input  logic                      alu_neg,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic [$clog2(NREGS)-1:0]  rsp_rd,
  output logic                      rsp_zero,
  output logic                      rsp_neg,
  output logic                      busy
);

  localparam int RW = $clog2(NREGS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state_reg, state_next;

  // ---------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------
  logic [OP_SEL-1:0]     fifo_op     [FIFO_DEPTH];
  logic [RW-1:0]         fifo_rs1    [FIFO_DEPTH];
  logic [RW-1:0]         fifo_rs2    [FIFO_DEPTH];
  logic [RW-1:0]         fifo_rd     [FIFO_DEPTH];
  logic                  fifo_use_imm[FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_imm    [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          push, pop, capture, fifo_empty;

  assign fifo_empty = (count_reg == '0);
  // Ready comes straight from the registered count, so a pop in the same
  // cycle does not make room until the following cycle.
  assign cmd_ready  = (count_reg != CW'(FIFO_DEPTH));
  assign push       = cmd_valid & cmd_ready;

  // Payload storage needs no reset: the count alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr_reg]      <= cmd_op;
      fifo_rs1[wr_ptr_reg]     <= cmd_rs1;
      fifo_rs2[wr_ptr_reg]     <= cmd_rs2;
      fifo_rd[wr_ptr_reg]      <= cmd_rd;
      fifo_use_imm[wr_ptr_reg] <= cmd_use_imm;
      fifo_imm[wr_ptr_reg]     <= cmd_imm;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
    end
  end

  // ---------------------------------------------------------------------
  // Register file; entry 0 is hard-wired to zero so writes to it vanish.
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rf [NREGS];
  logic [RW-1:0]         issue_rd_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_rf
      if (gi == 0) begin : g_zero
        assign rf[gi] = '0;
      end else begin : g_entry
        logic [DATA_WIDTH-1:0] q_reg;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)
            q_reg <= '0;
          else if (capture && (issue_rd_reg == RW'(gi)))
            q_reg <= alu_result;
        end
        assign rf[gi] = q_reg;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------
  logic rsp_valid_reg;

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        capture    = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        if (rsp_valid_reg && rsp_ready) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = ISSUE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // ---------------------------------------------------------------------
  // ALU operand latch. Operands are read at pop; the previous writeback
  // always lands at least one edge earlier, so no forwarding is needed.
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] alu_a_reg, alu_b_reg;
  logic [OP_SEL-1:0]     alu_op_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_reg    <= '0;
      alu_b_reg    <= '0;
      alu_op_reg   <= '0;
      issue_rd_reg <= '0;
    end else if (pop) begin
      alu_op_reg   <= fifo_op[rd_ptr_reg];
      alu_a_reg    <= rf[fifo_rs1[rd_ptr_reg]];
      alu_b_reg    <= fifo_use_imm[rd_ptr_reg] ? fifo_imm[rd_ptr_reg]
                                               : rf[fifo_rs2[rd_ptr_reg]];
      issue_rd_reg <= fifo_rd[rd_ptr_reg];
    end
  end

  assign alu_a  = alu_a_reg;
  assign alu_b  = alu_b_reg;
  assign alu_op = alu_op_reg;

  // ---------------------------------------------------------------------
  // Response register. Capture only happens in ISSUE, which never
  // coincides with a handshake, so the clear on handshake is unconditional.
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rsp_data_reg;
  logic [RW-1:0]         rsp_rd_reg;
  logic                  rsp_zero_reg, rsp_neg_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_rd_reg    <= '0;
      rsp_zero_reg  <= 1'b0;
      rsp_neg_reg   <= 1'b0;
    end else if (capture) begin
      rsp_valid_reg <= 1'b1;
      rsp_data_reg  <= alu_result;
      rsp_rd_reg    <= issue_rd_reg;
      rsp_zero_reg  <= alu_zero;
      rsp_neg_reg   <= alu_neg;
    end else if (rsp_valid_reg && rsp_ready) begin
      rsp_valid_reg <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_rd    = rsp_rd_reg;
  assign rsp_zero  = rsp_zero_reg;
  assign rsp_neg   = rsp_neg_reg;

  // busy looks ahead at the next count/state so it drops exactly one
  // cycle after the last handshake that leaves the block empty.
  logic busy_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_reg <= 1'b0;
    else        busy_reg <= (count_next != '0) || (state_next != IDLE);
  end

  assign busy = busy_reg;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: a small ALU stub, a transaction-level
// model compared against the DUT on every cycle, and directed vectors with
// hand-computed literal expectations.
module tb_alu_cmd_sequencer;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2,
                         OP_OR = 4'd3, OP_XOR = 4'd4, OP_SLL = 4'd5,
                         OP_SRL = 4'd6, OP_SRA = 4'd7, OP_LDB = 4'd8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [2:0]  cmd_rs1 = '0, cmd_rs2 = '0, cmd_rd = '0;
  logic        cmd_use_imm = 1'b0;
  logic [31:0] cmd_imm = '0;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_zero, alu_neg;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_rd;
  logic        rsp_zero, rsp_neg, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
    .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg), .busy(busy)
  );

  // Combinational ALU stand-in.
  function automatic logic [31:0] alu_f(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return 32'($signed(a) >>> b[4:0]);
      OP_LDB:  return b;
      default: return 32'd0;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_f(alu_op, alu_a, alu_b);
    alu_zero   = (alu_result == 32'd0);
    alu_neg    = alu_result[31];
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------------------------------------------------------------
  // Transaction-level model. Commands execute strictly in acceptance order
  // with writeback before the next read, so each result is computed the
  // moment the command is accepted. Timing: a command starts when nothing
  // is in flight; its response is valid from one edge after it starts
  // until the handshake.
  // ---------------------------------------------------------------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, res;
    logic [2:0]  rd;
  } txn_t;

  txn_t        q[$];
  txn_t        cur;
  bit          have_cur;
  int          cur_start;
  int          k;
  logic [31:0] mreg [8];
  logic [31:0] last_a, last_b;
  logic [3:0]  last_op;
  logic [31:0] got_data[$];
  int          got_edge[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      have_cur = 0;
      k = 0;
      for (int i = 0; i < 8; i++) mreg[i] = '0;
      last_a = '0; last_b = '0; last_op = '0;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
    end else begin
      bit exp_ready, exp_valid, hs, acc;
      exp_ready = (q.size() < DEPTH);
      exp_valid = have_cur && (k >= cur_start + 1);
      chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      chk("busy", 32'(busy), 32'((q.size() != 0) || have_cur));
      chk("alu_a", alu_a, last_a);
      chk("alu_b", alu_b, last_b);
      chk("alu_op", 32'(alu_op), 32'(last_op));
      if (exp_valid) begin
        chk("rsp_data", rsp_data, cur.res);
        chk("rsp_rd", 32'(rsp_rd), 32'(cur.rd));
        chk("rsp_zero", 32'(rsp_zero), 32'(cur.res == 32'd0));
        chk("rsp_neg", 32'(rsp_neg), 32'(cur.res[31]));
      end
      hs  = exp_valid && rsp_ready;
      acc = cmd_valid && exp_ready;
      if (hs) begin
        $display("rsp %0d: rd=%0d data=0x%08h zero=%0b neg=%0b",
                 got_data.size(), rsp_rd, rsp_data, rsp_zero, rsp_neg);
        got_data.push_back(rsp_data);
        got_edge.push_back(k + 1);
        have_cur = 0;
      end
      if (!have_cur && q.size() > 0) begin
        cur = q.pop_front();
        have_cur = 1;
        cur_start = k + 1;
        last_a = cur.a; last_b = cur.b; last_op = cur.op;
      end
      if (acc) begin
        txn_t t;
        t.op  = cmd_op;
        t.rd  = cmd_rd;
        t.a   = mreg[cmd_rs1];
        t.b   = cmd_use_imm ? cmd_imm : mreg[cmd_rs2];
        t.res = alu_f(t.op, t.a, t.b);
        if (cmd_rd != 3'd0) mreg[cmd_rd] = t.res;
        q.push_back(t);
      end
      k++;
    end
  end

  // ---------------------------------------------------------------------
  // Drivers (all run in the phase just after a rising edge)
  // ---------------------------------------------------------------------
  task automatic try_send(input logic [3:0] op, input logic [2:0] rd,
                          input logic [2:0] rs1, input logic [2:0] rs2,
                          input logic ui, input logic [31:0] imm,
                          input int max_cyc, output bit ok);
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_use_imm = ui; cmd_imm = imm; cmd_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      ok = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [2:0] rd,
                      input logic [2:0] rs1, input logic [2:0] rs2,
                      input logic ui, input logic [31:0] imm);
    bit ok;
    try_send(op, rd, rs1, rs2, ui, imm, 50, ok);
    chk("cmd_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 300 && got_data.size() < n; i++) begin
      @(posedge clk); #1;
    end
    chk("rsp_count", 32'(got_data.size()), 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    bit ok;
    int acc_n;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Immediate load with latency check
    base = got_data.size();
    send(OP_LDB, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5);
    chk("lat_e0_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_e1_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_e2_valid", 32'(rsp_valid), 32'd1);
    chk("ldb_data", rsp_data, 32'd5);
    chk("ldb_rd", 32'(rsp_rd), 32'd1);
    chk("ldb_flags", {30'd0, rsp_zero, rsp_neg}, 32'd0);

    // Register chain, r0 and SRA
    send(OP_ADD, 3'd2, 3'd1, 3'd0, 1'b1, 32'hFFFF_FFF9);
    send(OP_SUB, 3'd3, 3'd2, 3'd2, 1'b0, 32'd0);
    send(OP_LDB, 3'd0, 3'd0, 3'd0, 1'b1, 32'd9);
    send(OP_ADD, 3'd4, 3'd0, 3'd0, 1'b1, 32'd0);
    send(OP_LDB, 3'd5, 3'd0, 3'd0, 1'b1, 32'h8000_0000);
    send(OP_SRA, 3'd6, 3'd5, 3'd0, 1'b1, 32'd4);
    wait_rsp(base + 7);
    chk("add_neg_data", got_data[base+1], 32'hFFFF_FFFE);
    chk("sub_zero_data", got_data[base+2], 32'd0);
    chk("ldb_r0_data", got_data[base+3], 32'd9);
    chk("r0_read_data", got_data[base+4], 32'd0);
    chk("sra_data", got_data[base+6], 32'hF800_0000);

    // Backpressure and full FIFO
    base = got_data.size();
    rsp_ready = 1'b0;
    acc_n = 0;
    try_send(OP_LDB, 3'd1, 3'd0, 3'd0, 1'b1, 32'd10, 3, ok); acc_n += int'(ok);
    try_send(OP_ADD, 3'd1, 3'd1, 3'd0, 1'b1, 32'd1, 3, ok);  acc_n += int'(ok);
    try_send(OP_ADD, 3'd2, 3'd1, 3'd1, 1'b0, 32'd0, 3, ok);  acc_n += int'(ok);
    try_send(OP_SUB, 3'd3, 3'd2, 3'd0, 1'b1, 32'd30, 3, ok); acc_n += int'(ok);
    try_send(OP_XOR, 3'd4, 3'd3, 3'd2, 1'b0, 32'd0, 3, ok);  acc_n += int'(ok);
    try_send(OP_OR,  3'd5, 3'd1, 3'd0, 1'b1, 32'd3, 4, ok);  acc_n += int'(ok);
    chk("full_accepted", 32'(acc_n), 32'd5);
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("stall_rsp_data", rsp_data, 32'd10);
    rsp_ready = 1'b1;
    wait_rsp(base + 5);
    chk("bp_rsp0", got_data[base+0], 32'd10);
    chk("bp_rsp1", got_data[base+1], 32'd11);
    chk("bp_rsp2", got_data[base+2], 32'd22);
    chk("bp_rsp3", got_data[base+3], 32'hFFFF_FFF8);
    chk("bp_rsp4", got_data[base+4], 32'hFFFF_FFEE);
    for (int i = 1; i < 5; i++)
      chk("bp_spacing", 32'(got_edge[base+i] - got_edge[base+i-1]), 32'd2);

    // Simultaneous push and pop with FIFO_DEPTH-1 entries queued
    base = got_data.size();
    rsp_ready = 1'b0;
    send(OP_LDB, 3'd1, 3'd0, 3'd0, 1'b1, 32'd100);
    send(OP_ADD, 3'd2, 3'd1, 3'd0, 1'b1, 32'd1);
    send(OP_ADD, 3'd3, 3'd2, 3'd0, 1'b1, 32'd1);
    send(OP_ADD, 3'd4, 3'd3, 3'd0, 1'b1, 32'd1);
    repeat (2) begin @(posedge clk); #1; end
    chk("sim_pre_valid", 32'(rsp_valid), 32'd1);
    cmd_op = OP_ADD; cmd_rd = 3'd5; cmd_rs1 = 3'd4; cmd_rs2 = 3'd0;
    cmd_use_imm = 1'b1; cmd_imm = 32'd1;
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    chk("sim_pre_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    chk("sim_post_ready", 32'(cmd_ready), 32'd1);
    acc_n = 0;
    try_send(OP_ADD, 3'd6, 3'd5, 3'd0, 1'b1, 32'd1, 2, ok); acc_n += int'(ok);
    try_send(OP_ADD, 3'd7, 3'd6, 3'd0, 1'b1, 32'd1, 3, ok); acc_n += int'(ok);
    chk("sim_room_left", 32'(acc_n), 32'd1);
    rsp_ready = 1'b1;
    wait_rsp(base + 6);
    for (int i = 0; i < 6; i++)
      chk("sim_order", got_data[base+i], 32'd100 + 32'(i));

    // Reset in the middle of ISSUE
    send(OP_LDB, 3'd1, 3'd1, 3'd0, 1'b1, 32'd77);
    @(posedge clk); #1;
    chk("pre_rst_alu_a", alu_a, 32'd100);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base = got_data.size();
    send(OP_ADD, 3'd2, 3'd1, 3'd0, 1'b1, 32'd0);
    wait_rsp(base + 1);
    chk("post_rst_r1", got_data[base], 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("final_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
